// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with capture FIFO and port-bus registers; optional UART_RX_ERR_DISCARD_EN drops perr/ferr frames
module uart_rx_ctrl #(
  parameter int          DEPTH        = 4,
  parameter int          CLK_HZ       = 100000000,
  parameter logic [2:0]  BAUD_DEFAULT = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_perr,
  input  logic        rx_ferr,
  input  logic        rx_ovf,
  output logic        reads0,
  output logic        eight,
  output logic        pen,
  output logic        even,
  output logic [18:0] k,
  input  logic [1:0]  port_id,
  input  logic        rd_stb,
  input  logic        wr_stb,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic        irq,
  input  logic        irq_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [18:0] K_300    = 19'(CLK_HZ / 300 - 1);
  localparam logic [18:0] K_1200   = 19'(CLK_HZ / 1200 - 1);
  localparam logic [18:0] K_2400   = 19'(CLK_HZ / 2400 - 1);
  localparam logic [18:0] K_4800   = 19'(CLK_HZ / 4800 - 1);
  localparam logic [18:0] K_9600   = 19'(CLK_HZ / 9600 - 1);
  localparam logic [18:0] K_19200  = 19'(CLK_HZ / 19200 - 1);
  localparam logic [18:0] K_38400  = 19'(CLK_HZ / 38400 - 1);
  localparam logic [18:0] K_115200 = 19'(CLK_HZ / 115200 - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t         state;
  logic [10:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_ovf;
  logic [2:0]     baud_sel;
  logic           fifo_empty;
  logic           fifo_full;
  logic [10:0]    head;
  logic [10:0]    entry;
  logic           capture;
  logic           discard;
  logic           push_req;
  logic           push;
  logic           push_drop;
  logic           pop;
  logic           stat_rd;
  logic [7:0]     status;
  logic           unused_ok;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign head       = mem[rd_ptr];
  // In 7-bit modes the engine's bit 7 is not part of the character
  assign entry      = {rx_ovf, rx_ferr, rx_perr, rx_data[7] & eight, rx_data[6:0]};
  assign capture    = (state == S_CAPTURE);

`ifdef UART_RX_ERR_DISCARD_EN
  logic [7:0] err_cnt;
  logic       err_rd;
  assign discard = rx_perr | rx_ferr;
  assign err_rd  = rd_stb && (port_id == 2'd3);
`else
  assign discard = 1'b0;
`endif

  assign push_req  = capture & ~discard;
  assign pop       = rd_stb && (port_id == 2'd0) && !fifo_empty;
  // A pop in the same cycle frees the slot the push needs
  assign push      = push_req & (~fifo_full | pop);
  assign push_drop = push_req & fifo_full & ~pop;
  assign stat_rd   = rd_stb && (port_id == 2'd1);

  // Head flags are meaningless when empty, so they read as zero
  assign status = {fifo_full, fifo_empty, fifo_ovf,
                   fifo_empty ? 3'b000 : {head[8], head[9], head[10]}, 2'b00};

  assign unused_ok = &{1'b0, out_port[7:3]};

  // Frame sequencer: one capture and one reads0 pulse per RxRdy assertion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      reads0 <= 1'b0;
    end else begin
      reads0 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_rdy) begin
            state  <= S_CAPTURE;
            reads0 <= 1'b1;
          end
        end
        S_CAPTURE: state <= S_WAIT;
        S_WAIT: begin
          if (!rx_rdy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a same-cycle status read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_ovf <= 1'b0;
    end else if (push_drop) begin
      fifo_ovf <= 1'b1;
    end else if (stat_rd) begin
      fifo_ovf <= 1'b0;
    end
  end

  // Interrupt level: an accepted push beats a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else if (push) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

  // CPU-written frame configuration and baud select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eight    <= 1'b1;
      pen      <= 1'b0;
      even     <= 1'b0;
      baud_sel <= BAUD_DEFAULT;
    end else if (wr_stb) begin
      if (port_id == 2'd2) begin
        even  <= out_port[2];
        pen   <= out_port[1];
        eight <= out_port[0];
      end
      if (port_id == 2'd3) baud_sel <= out_port[2:0];
    end
  end

`ifdef UART_RX_ERR_DISCARD_EN
  // Saturating count of discarded error frames, cleared by reading it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'h00;
    end else if (err_rd) begin
      err_cnt <= {7'b0, capture & discard};
    end else if (capture && discard && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  // Bit-time count for the selected baud rate
  always_comb begin
    k = K_9600;
    case (baud_sel)
      3'd0:    k = K_300;
      3'd1:    k = K_1200;
      3'd2:    k = K_2400;
      3'd3:    k = K_4800;
      3'd4:    k = K_9600;
      3'd5:    k = K_19200;
      3'd6:    k = K_38400;
      3'd7:    k = K_115200;
      default: k = K_9600;
    endcase
  end

  // Port-bus read mux
  always_comb begin
    in_port = 8'h00;
    case (port_id)
      2'd0: in_port = fifo_empty ? 8'h00 : head[7:0];
      2'd1: in_port = status;
      2'd2: in_port = {5'b0, even, pen, eight};
`ifdef UART_RX_ERR_DISCARD_EN
      2'd3: in_port = err_cnt;
`else
      2'd3: in_port = {5'b0, baud_sel};
`endif
      default: in_port = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_perr = 1'b0;
  logic        rx_ferr = 1'b0;
  logic        rx_ovf = 1'b0;
  logic        reads0;
  logic        eight;
  logic        pen;
  logic        even;
  logic [18:0] k;
  logic [1:0]  port_id = 2'd0;
  logic        rd_stb = 1'b0;
  logic        wr_stb = 1'b0;
  logic [7:0]  out_port = 8'h00;
  logic [7:0]  in_port;
  logic        irq;
  logic        irq_ack = 1'b0;

  int total = 0;
  int bad = 0;
  int r0_cnt = 0;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovf(rx_ovf),
    .reads0(reads0), .eight(eight), .pen(pen), .even(even), .k(k),
    .port_id(port_id), .rd_stb(rd_stb), .wr_stb(wr_stb), .out_port(out_port),
    .in_port(in_port), .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // counts every cycle reads0 is high
  always @(negedge clk) if (reads0) r0_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    port_id = a;
    #1;
    d = in_port;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    port_id = a;
    rd_stb = 1'b1;
    #1;
    d = in_port;
    @(negedge clk);
    rd_stb = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    port_id = a;
    out_port = d;
    wr_stb = 1'b1;
    @(negedge clk);
    wr_stb = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    int n;
    @(negedge clk);
    rx_data = d;
    rx_perr = pe;
    rx_ferr = fe;
    rx_ovf = ov;
    rx_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!reads0 && n < 8);
    if (!reads0) check("reads0_seen", 0, 1);
    rx_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rx_perr = 1'b0;
    rx_ferr = 1'b0;
    rx_ovf = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int r0_base;
    logic [7:0] exp_bytes [4];

    // reset defaults
    repeat (3) @(negedge clk);
    check("rst_reads0", reads0, 0);
    check("rst_irq", irq, 0);
    check("rst_cfg", {eight, pen, even}, 3'b100);
    check("rst_k", k, 19'd10415);
    peek(2'd1, d);
    check("rst_status", d, 8'h40);
    rst = 1'b1;
    @(negedge clk);
    peek(2'd2, d);
    check("rst_ctrl_rb", d, 8'h01);
`ifdef UART_RX_ERR_DISCARD_EN
    peek(2'd3, d);
    check("rst_errcnt", d, 8'h00);
`else
    peek(2'd3, d);
    check("rst_baud_rb", d, 8'h04);
`endif
    cpu_rd(2'd0, d);
    check("empty_rd", d, 8'h00);
    peek(2'd1, d);
    check("empty_rd_status", d, 8'h40);

    // single frame with latency and no double capture
    @(negedge clk);
    rx_data = 8'hA5;
    rx_rdy = 1'b1;
    @(negedge clk);
    check("single_reads0_t1", reads0, 1);
    @(negedge clk);
    check("single_reads0_off", reads0, 0);
    check("single_irq", irq, 1);
    peek(2'd1, d);
    check("single_status", d, 8'h00);
    rx_rdy = 1'b0;
    @(negedge clk);
    cpu_rd(2'd0, d);
    check("single_data", d, 8'hA5);
    peek(2'd1, d);
    check("single_status_empty", d, 8'h40);
    check("single_irq_kept", irq, 1);
    check("single_r0_cnt", r0_cnt, 1);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check("irq_ack_clears", irq, 0);

    // overflow: five frames into four slots
    r0_base = r0_cnt;
    send(8'h11, 0, 0, 0);
    send(8'h22, 0, 0, 0);
    send(8'h33, 0, 0, 0);
    send(8'h44, 0, 0, 0);
    send(8'h55, 0, 0, 0);
    check("ovf_r0_cnt", r0_cnt - r0_base, 5);
    cpu_rd(2'd1, d);
    check("ovf_status", d, 8'hA0);
    peek(2'd1, d);
    check("ovf_cleared", d, 8'h80);
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cpu_rd(2'd0, d);
      check($sformatf("ovf_data%0d", i), d, exp_bytes[i]);
    end
    peek(2'd1, d);
    check("ovf_drained", d, 8'h40);

    // push and pop in the same cycle at full
    send(8'h01, 0, 0, 0);
    send(8'h02, 0, 0, 0);
    send(8'h03, 0, 0, 0);
    send(8'h04, 0, 0, 0);
    @(negedge clk);
    rx_data = 8'h05;
    rx_rdy = 1'b1;
    @(negedge clk);
    check("pp_capture", reads0, 1);
    port_id = 2'd0;
    rd_stb = 1'b1;
    #1;
    check("pp_pop_data", in_port, 8'h01);
    @(negedge clk);
    rd_stb = 1'b0;
    rx_rdy = 1'b0;
    peek(2'd1, d);
    check("pp_status", d, 8'h80);
    @(negedge clk);
    exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h03; exp_bytes[2] = 8'h04; exp_bytes[3] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      cpu_rd(2'd0, d);
      check($sformatf("pp_data%0d", i), d, exp_bytes[i]);
    end

    // error flags
`ifdef UART_RX_ERR_DISCARD_EN
    r0_base = r0_cnt;
    send(8'h3C, 0, 1, 0);
    check("disc_r0", r0_cnt - r0_base, 1);
    peek(2'd1, d);
    check("disc_status", d, 8'h40);
    cpu_rd(2'd3, d);
    check("disc_errcnt", d, 8'h01);
    peek(2'd3, d);
    check("disc_errcnt_clr", d, 8'h00);
`else
    send(8'h3C, 0, 1, 0);
    peek(2'd1, d);
    check("ferr_status", d, 8'h08);
    cpu_rd(2'd0, d);
    check("ferr_data", d, 8'h3C);
    send(8'h5A, 1, 0, 1);
    peek(2'd1, d);
    check("perr_ovf_status", d, 8'h14);
    cpu_rd(2'd0, d);
    check("perr_data", d, 8'h5A);
`endif

    // 7-bit mode masks bit 7
    cpu_wr(2'd2, 8'h00);
    check("cfg_7bit", {eight, pen, even}, 3'b000);
    send(8'hFF, 0, 0, 0);
    cpu_rd(2'd0, d);
    check("7bit_data", d, 8'h7F);

    // config writes take effect next cycle
    cpu_wr(2'd2, 8'h07);
    check("cfg_all", {eight, pen, even}, 3'b111);
    peek(2'd2, d);
    check("cfg_rb", d, 8'h07);
    cpu_wr(2'd3, 8'h07);
    check("k_115200", k, 19'd867);
`ifndef UART_RX_ERR_DISCARD_EN
    peek(2'd3, d);
    check("baud_rb", d, 8'h07);
`endif
    cpu_wr(2'd3, 8'h00);
    check("k_300", k, 19'd333332);

    // irq_ack on the same cycle as a push keeps irq set
    check("race_irq_pre", irq, 1);
    @(negedge clk);
    rx_data = 8'h66;
    rx_rdy = 1'b1;
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    rx_rdy = 1'b0;
    check("race_irq", irq, 1);
    @(negedge clk);

    // asynchronous reset mid-operation
    cpu_wr(2'd2, 8'h06);
    send(8'h77, 0, 0, 0);
    port_id = 2'd1;
    #2;
    rst = 1'b0;
    #1;
    check("arst_status", in_port, 8'h40);
    check("arst_irq", irq, 0);
    check("arst_cfg", {eight, pen, even}, 3'b100);
    check("arst_k", k, 19'd10415);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
